// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM of the multicycle RV32I core. Sequences the
//            shared ALU and the unified memory port across several cycles per
//            instruction and drives every select, enable and strobe.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               ALUR31,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  // Opcodes recognised in DECODE
  localparam logic [6:0] c_op_lw    = 7'b0000011;
  localparam logic [6:0] c_op_sw    = 7'b0100011;
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  // ALU operation codes
  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_xor = 3'b100;
  localparam logic [2:0] c_alu_slt = 3'b101;
  localparam logic [2:0] c_alu_sll = 3'b110;
  localparam logic [2:0] c_alu_srl = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_mem_req;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_imm_src;
  logic [2:0] w_alu_ctrl;
  logic       w_done;
  logic       w_illegal;

  logic [2:0] w_alu_dec;
  logic       w_alu_trap;
  logic       w_br_ok;
  logic       w_taken;

  // State register; reset (re)starts at FETCH and abandons any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // ALU operation from funct3/funct7b5; unsupported encodings (sra, 011) trap
  always_comb begin
    w_alu_dec  = c_alu_add;
    w_alu_trap = 1'b0;
    case (funct3)
      3'b000: w_alu_dec = (op == c_op_r && funct7b5) ? c_alu_sub : c_alu_add;
      3'b001: w_alu_dec = c_alu_sll;
      3'b010: w_alu_dec = c_alu_slt;
      3'b011: w_alu_trap = 1'b1;
      3'b100: w_alu_dec = c_alu_xor;
      3'b101: begin
        w_alu_dec  = c_alu_srl;
        w_alu_trap = funct7b5;
      end
      3'b110: w_alu_dec = c_alu_or;
      3'b111: w_alu_dec = c_alu_and;
    endcase
  end

  // Branch condition from the subtract flags; only beq/bne/blt/bge are legal
  always_comb begin
    w_br_ok = 1'b1;
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = ALUR31;
      3'b101:  w_taken = ~ALUR31;
      default: w_br_ok = 1'b0;
    endcase
  end

  // Next-state and per-state control decode; anything unlisted stays 0 / add
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_imm_src    = 3'b000;
    w_alu_ctrl   = c_alu_add;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC+imm as the branch/jump target
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = (op == c_op_jal) ? 3'b011 : 3'b010;
        case (op)
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_r:           w_next = S_EXECR;
          c_op_i:           w_next = S_EXECI;
          c_op_br:          w_next = w_br_ok ? S_BRANCH : S_TRAP;
          c_op_jal:         w_next = S_JAL;
          c_op_jalr:        w_next = S_JALR;
          c_op_lui:         w_next = S_LUI;
          c_op_auipc:       w_next = S_AUIPC;
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = (op == c_op_sw) ? 3'b001 : 3'b000;
        w_next      = (op == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobes stay constant while the memory stalls
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_ctrl  = w_alu_dec;
        w_next      = w_alu_trap ? S_TRAP : S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_ctrl  = w_alu_dec;
        w_next      = w_alu_trap ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_ctrl  = c_alu_sub;
        w_pc_write  = w_taken;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_JALR: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
        w_next       = S_LINK;
      end
      S_LINK: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_next      = S_ALUWB;
      end
      S_LUI: begin
        w_imm_src    = 3'b100;
        w_result_src = 2'b11;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      S_AUIPC: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = 3'b100;
        w_next      = S_ALUWB;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  // Every output is held at 0 while reset is asserted
  assign mem_req    = w_mem_req   & ~reset;
  assign AdrSrc     = w_adr_src   & ~reset;
  assign MemWrite   = w_mem_write & ~reset;
  assign IRWrite    = w_ir_write  & ~reset;
  assign PCWrite    = w_pc_write  & ~reset;
  assign RegWrite   = w_reg_write & ~reset;
  assign instr_done = w_done      & ~reset;
  assign illegal    = w_illegal   & ~reset;
  assign ResultSrc  = reset ? 2'b00 : w_result_src;
  assign ALUSrcA    = reset ? 2'b00 : w_alu_src_a;
  assign ALUSrcB    = reset ? 2'b00 : w_alu_src_b;
  assign ImmSrc     = reset ? 3'b000 : w_imm_src;
  assign ALUControl = reset ? 3'b000 : w_alu_ctrl;
  assign state_dbg  = reset ? '0 : r_state;

endmodule
`default_nettype wire
